// File: rtl/dadda_mac_pkg.sv
// ----------------------------------------------------------------------------
// dadda_mac_pkg : shared widths and pipeline-stage types, rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dadda_mac_pkg;

  localparam int OPER_W    = 16;
  localparam int PROD_W    = 32;
  localparam int ACC_W_DEF = 40;
  localparam int CNT_W_DEF = 8;

  typedef struct packed {
    logic [OPER_W-1:0] a;
    logic [OPER_W-1:0] b;
    logic              last;
    logic              valid;
  } s1_t;

  typedef struct packed {
    logic [PROD_W-1:0] prod;
    logic              last;
    logic              valid;
  } s2_t;

endpackage

`default_nettype wire

// File: rtl/dadda_16x16_uncompressed2.sv
// ----------------------------------------------------------------------------
// dadda_16x16_uncompressed2 : combinational 16x16 unsigned multiplier, rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dadda_16x16_uncompressed2
  import dadda_mac_pkg::*;
(
  input  logic [OPER_W-1:0] a,
  input  logic [OPER_W-1:0] b,
  output logic [PROD_W-1:0] final_result
);

  logic [PROD_W-1:0] sum_v;
  logic [PROD_W-1:0] carry_v;
  logic [PROD_W-1:0] pp;
  logic [PROD_W-1:0] s_new;
  logic [PROD_W-1:0] c_new;

  // Partial products are folded into a sum/carry pair with 3:2 compressors so
  // only one carry-propagate adder sits at the end of the tree.
  always_comb begin
    sum_v   = '0;
    carry_v = '0;
    pp      = '0;
    s_new   = '0;
    c_new   = '0;
    for (int i = 0; i < OPER_W; i++) begin
      pp      = b[i] ? (PROD_W'(a) << i) : '0;
      s_new   = sum_v ^ carry_v ^ pp;
      c_new   = ((sum_v & carry_v) | (sum_v & pp) | (carry_v & pp)) << 1;
      sum_v   = s_new;
      carry_v = c_new;
    end
    final_result = sum_v + carry_v;
  end

endmodule

`default_nettype wire

// File: rtl/dadda_mac_16x16.sv
// ----------------------------------------------------------------------------
// dadda_mac_16x16 : pipelined 16x16 multiply-accumulate over grouped terms, rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dadda_mac_16x16
  import dadda_mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPER_W-1:0] in_a,
  input  logic [OPER_W-1:0] in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_ovf
);

  s1_t              s1;
  s2_t              s2;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic              stall;
  logic [PROD_W-1:0] prod;
  logic [ACC_W:0]    sum_ext;
  logic [CNT_W-1:0]  cnt_n;
  logic              ovf_n;
  logic              load_out;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall & ~acc_clr & ~rst;

  dadda_16x16_uncompressed2 u_mult (
    .a           (s1.a),
    .b           (s1.b),
    .final_result(prod)
  );

  assign sum_ext  = {1'b0, acc} + (ACC_W+1)'(s2.prod);
  assign cnt_n    = (&cnt) ? cnt : cnt + CNT_W'(1);
  assign ovf_n    = ovf | sum_ext[ACC_W];
  assign load_out = ~acc_clr & ~stall & s2.valid & s2.last;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= '0;
      s2        <= '0;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_cnt   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (acc_clr) begin
        s1.valid <= 1'b0;
        s2.valid <= 1'b0;
        acc      <= '0;
        cnt      <= '0;
        ovf      <= 1'b0;
      end else if (!stall) begin
        // in_ready is high on this path, so in_valid alone marks an accepted beat
        s1 <= '{a: in_a, b: in_b, last: in_last, valid: in_valid};
        s2 <= '{prod: prod, last: s1.last, valid: s1.valid};
        if (s2.valid) begin
          if (s2.last) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
          end else begin
            acc <= sum_ext[ACC_W-1:0];
            cnt <= cnt_n;
            ovf <= ovf_n;
          end
        end
      end

      if (load_out) begin
        out_valid <= 1'b1;
        out_acc   <= sum_ext[ACC_W-1:0];
        out_cnt   <= cnt_n;
        out_ovf   <= ovf_n;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dadda_mac_16x16.sv
// ----------------------------------------------------------------------------
// tb_dadda_mac_16x16 : bench for the 40-bit and 32-bit accumulator builds, rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dadda_mac_16x16;
  import dadda_mac_pkg::*;

  logic        clk = 1'b0;
  logic        rst, acc_clr, in_valid, in_last, out_ready;
  logic [15:0] in_a, in_b;

  logic        in_ready, out_valid, out_ovf;
  logic [39:0] out_acc;
  logic [7:0]  out_cnt;
  logic        in_ready32, out_valid32, out_ovf32;
  logic [31:0] out_acc32;
  logic [7:0]  out_cnt32;

  always #5 clk = ~clk;

  dadda_mac_16x16 #(.ACC_W(40), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .acc_clr(acc_clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_acc(out_acc), .out_cnt(out_cnt), .out_ovf(out_ovf)
  );

  dadda_mac_16x16 #(.ACC_W(32), .CNT_W(8)) dut32 (
    .clk(clk), .rst(rst), .acc_clr(acc_clr), .in_valid(in_valid), .in_ready(in_ready32),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid32),
    .out_ready(out_ready), .out_acc(out_acc32), .out_cnt(out_cnt32), .out_ovf(out_ovf32)
  );

  // Reference: exact group sum in 64 bits; wrap, overflow and count come from it.
  typedef struct {
    longint unsigned total;
    int              n;
  } grp_t;

  grp_t            q[$];
  longint unsigned g_total;
  int              g_n;
  int              checks = 0;
  int              passes = 0;
  int              cyc_no = 0;
  logic [2:0]      hist;
  bit              timing_en, rnd_ordy, prev_rst;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc_no);
  endtask

  task automatic cyc(input logic v, input logic [15:0] a, input logic [15:0] b,
                     input logic l, input logic clr, input logic ordy, input logic r,
                     output logic accepted);
    logic ordy_e;
    logic exp_ir;
    grp_t h;
    @(negedge clk);
    ordy_e    = rnd_ordy ? ($urandom_range(0, 3) != 0) : ordy;
    rst       = r;
    acc_clr   = clr;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_last   = l;
    out_ready = ordy_e;
    #1;
    cyc_no++;
    if (prev_rst) begin
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_acc", 64'(out_acc), 64'd0);
      chk("rst_out_cnt", 64'(out_cnt), 64'd0);
      chk("rst_out_ovf", 64'(out_ovf), 64'd0);
      chk("rst_out_valid32", 64'(out_valid32), 64'd0);
    end
    exp_ir = !(out_valid && !ordy_e) && !clr && !r;
    chk("in_ready", 64'(in_ready), 64'(exp_ir));
    chk("in_ready32", 64'(in_ready32), 64'(exp_ir));
    if (timing_en) begin
      chk("out_valid_latency", 64'(out_valid), 64'(hist[2]));
      chk("out_valid_latency32", 64'(out_valid32), 64'(hist[2]));
    end
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 64'(out_valid), 64'd0);
      end else begin
        h = q[0];
        chk("out_acc40", 64'(out_acc), h.total & 64'hFF_FFFF_FFFF);
        chk("out_cnt40", 64'(out_cnt), 64'((h.n > 255) ? 255 : h.n));
        chk("out_ovf40", 64'(out_ovf), 64'((h.total >> 40) != 0));
        chk("out_acc32", 64'(out_acc32), h.total & 64'hFFFF_FFFF);
        chk("out_cnt32", 64'(out_cnt32), 64'((h.n > 255) ? 255 : h.n));
        chk("out_ovf32", 64'(out_ovf32), 64'((h.total >> 32) != 0));
        if (ordy_e) void'(q.pop_front());
      end
    end
    accepted = v && (in_ready === 1'b1);
    if (r) begin
      q.delete();
      g_total = 0;
      g_n     = 0;
      hist    = '0;
    end else if (clr) begin
      g_total = 0;
      g_n     = 0;
      hist    = '0;
    end else begin
      if (accepted) begin
        g_total += longint'(a) * longint'(b);
        g_n++;
        if (l) begin
          q.push_back('{total: g_total, n: g_n});
          g_total = 0;
          g_n     = 0;
        end
      end
      hist = {hist[1:0], accepted && l};
    end
    prev_rst = r;
  endtask

  task automatic idle(input int n);
    logic ok;
    repeat (n) cyc(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, ok);
  endtask

  task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic l);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) cyc(1'b1, a, b, l, 1'b0, 1'b1, 1'b0, ok);
    if (!ok) chk("beat_timeout", 64'(ok), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        ok;
    logic [15:0] la[3];
    logic [15:0] lb[3];
    logic        ll[3];
    int          idx;
    int          len;

    rst = 1'b1; acc_clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b1;
    g_total = 0; g_n = 0; hist = '0;
    timing_en = 1'b0; rnd_ordy = 1'b0; prev_rst = 1'b0;

    cyc(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, ok);
    cyc(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, ok);
    idle(1);
    timing_en = 1'b1;

    // Three-term group: 12 + 30 + 56 = 0x62
    beat(16'd3, 16'd4, 1'b0);
    beat(16'd5, 16'd6, 1'b0);
    beat(16'd7, 16'd8, 1'b1);
    idle(5);

    beat(16'hFFFF, 16'hFFFF, 1'b1);
    idle(5);

    // Wraps the 32-bit build, not the 40-bit one
    beat(16'hFFFF, 16'hFFFF, 1'b0);
    beat(16'hFFFF, 16'hFFFF, 1'b1);
    beat(16'd1, 16'd1, 1'b1);
    idle(5);

    beat(16'd1, 16'd2, 1'b1);
    beat(16'd2, 16'd3, 1'b1);
    idle(5);

    // Backpressure while a group is streaming
    timing_en = 1'b0;
    cyc(1'b1, 16'd10, 16'd10, 1'b1, 1'b0, 1'b0, 1'b0, ok);
    la = '{16'd1, 16'd2, 16'd3};
    lb = '{16'd1, 16'd2, 16'd3};
    ll = '{1'b0, 1'b0, 1'b1};
    idx = 0;
    repeat (8) begin
      if (idx < 3) cyc(1'b1, la[idx], lb[idx], ll[idx], 1'b0, 1'b0, 1'b0, ok);
      else         cyc(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, ok);
      if (ok) idx++;
    end
    for (int k = 0; k < 20 && idx < 3; k++) begin
      cyc(1'b1, la[idx], lb[idx], ll[idx], 1'b0, 1'b1, 1'b0, ok);
      if (ok) idx++;
    end
    if (idx < 3) chk("stall_release_timeout", 64'(idx), 64'd3);
    idle(8);
    timing_en = 1'b1;

    // Flush mid-group; the beat offered alongside acc_clr must be refused
    beat(16'd5, 16'd5, 1'b0);
    beat(16'd6, 16'd6, 1'b0);
    cyc(1'b1, 16'd9, 16'd9, 1'b1, 1'b1, 1'b1, 1'b0, ok);
    chk("clr_refuses_beat", 64'(ok), 64'd0);
    beat(16'd2, 16'd2, 1'b1);
    idle(5);

    // 260 maximal terms: counter saturates and both builds overflow
    for (int i = 0; i < 260; i++) beat(16'hFFFF, 16'hFFFF, i == 259);
    idle(5);

    timing_en = 1'b0;
    rnd_ordy  = 1'b1;
    for (int g = 0; g < 40; g++) begin
      len = $urandom_range(1, 4);
      for (int j = 0; j < len; j++) begin
        beat(16'($urandom), 16'($urandom), j == len - 1);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    rnd_ordy = 1'b0;
    idle(10);
    timing_en = 1'b1;

    // Reset mid-group: nothing may come out
    beat(16'd7, 16'd7, 1'b0);
    beat(16'd8, 16'd8, 1'b0);
    cyc(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, ok);
    idle(6);
    beat(16'd4, 16'd5, 1'b1);
    idle(5);

    chk("results_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
